muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width; legal values are even and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, operation request, sampled on the rising edge.
REQ-005 The block SHALL have port op, input, 2 bits, operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have port a, input, WIDTH bits, multiplicand or dividend (rs).
REQ-007 The block SHALL have port b, input, WIDTH bits, multiplier or divisor (rt).
REQ-008 The block SHALL have ports mthi and mtlo, inputs, 1 bit each, direct writes of wdata into hi or lo.
REQ-009 The block SHALL have port wdata, input, WIDTH bits, data for mthi and mtlo.
REQ-010 The block SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit, single-cycle completion pulse.
REQ-012 The block SHALL have ports hi and lo, outputs, WIDTH bits each, registered result.
REQ-013 The block SHALL have port div_by_zero, output, 1 bit, qualified by done.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-015 In IDLE with start=1, the block SHALL capture a, b and op, then enter RUN; operands changing afterwards SHALL have no effect.
REQ-016 RUN SHALL last exactly WIDTH cycles with busy=1: iterative shift-add for multiply, restoring shift-subtract for divide, one bit per cycle.
REQ-017 hi and lo SHALL update on the edge that leaves RUN; in the following cycle done=1 and busy=0, giving done WIDTH+1 edges after the start edge.
REQ-018 done SHALL be 1 for exactly one cycle per accepted operation.
REQ-019 A start asserted in the done cycle SHALL be accepted, giving back-to-back operations.
REQ-020 start, mthi and mtlo asserted while busy=1 SHALL be ignored.
REQ-021 For multiply, {hi,lo} SHALL equal the full 2*WIDTH-bit product: two's-complement for MULT, unsigned for MULTU.
REQ-022 For divide, lo SHALL equal the quotient and hi the remainder.
REQ-023 Signed DIV SHALL truncate the quotient toward zero, and the remainder SHALL take the sign of the dividend.
REQ-024 For divisor 0, the block SHALL still take the full latency and then set lo=all ones, hi=captured a, div_by_zero=1 in the done cycle.
REQ-025 div_by_zero SHALL be 0 in every other cycle.
REQ-026 For signed DIV of the most-negative value by -1, the block SHALL set lo=the most-negative value and hi=0, with no flag.
REQ-027 In IDLE, mthi=1 SHALL write wdata to hi and mtlo=1 SHALL write wdata to lo on the next edge; both may be asserted together.
REQ-028 In IDLE, if start and mthi/mtlo are asserted in the same cycle, start SHALL win and the writes SHALL be dropped.
REQ-029 hi and lo SHALL hold their value while busy and SHALL be unchanged by the operation until completion.

Reset
REQ-030 While reset=0, the block SHALL force asynchronously: state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, and internal counter and operand registers to 0.
REQ-031 A reset asserted mid-operation SHALL abort it, producing no done pulse and no hi/lo update after release.
REQ-032 After reset release, the first start SHALL be accepted on the first rising edge.

Verification (WIDTH=32)
REQ-033 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 32 cycles; done on cycle 33; hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIV a=0xFFFFFFF9 (-7), b=2 issued back-to-back in the done cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 DIVU a=100, b=0 -> done with div_by_zero=1, hi=0x00000064, lo=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
REQ-036 Idle mthi with wdata=0x12345678 -> hi=0x12345678; then start MULTU 6*7 with mtlo=1 and a second start both asserted during busy -> both ignored; result hi=0, lo=42, exactly one done pulse.
REQ-037 reset driven low 10 cycles into DIVU 1000/3 -> busy=0, hi=lo=0 immediately; no done pulse after release; a new DIVU 1000/3 -> lo=333, hi=1.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one result bit per cycle, HI/LO result registers.
// Signed operations run on operand magnitudes; the sign is restored on the final edge.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic               signed_op;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] product, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               div0;

    // Single iteration step, shared by both operations.
    always_comb begin
        signed_op = ~op[0];
        abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
        abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;

        mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, bmag_q} : '0);
        div_trial = {work_hi_q, work_lo_q[WIDTH-1]} - {1'b0, bmag_q};

        if (is_div_q) begin
            // Restoring division: keep the shifted remainder when the trial goes negative.
            if (!div_trial[WIDTH]) begin
                step_hi = div_trial[WIDTH-1:0];
                step_lo = {work_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = {work_hi_q[WIDTH-2:0], work_lo_q[WIDTH-1]};
                step_lo = {work_lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo_q[WIDTH-1:1]};
        end

        product  = {step_hi, step_lo};
        prod_fix = neg_res_q ? -product : product;
        quo_fix  = neg_res_q ? -step_lo : step_lo;
        rem_fix  = neg_rem_q ? -step_hi : step_hi;
        div0     = is_div_q && (bmag_q == '0);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        a_d       = a_q;
        bmag_d    = bmag_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = CW'(WIDTH - 1);
                    is_div_d  = op[1];
                    neg_res_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = signed_op & a[WIDTH-1];
                    a_d       = a;
                    bmag_d    = abs_b;
                    work_hi_d = '0;
                    work_lo_d = abs_a;
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            RUN: begin
                work_hi_d = step_hi;
                work_lo_d = step_lo;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (div0) begin
                        hi_d  = a_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_q       <= '0;
            bmag_q    <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            a_q       <= a_d;
            bmag_q    <= bmag_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: cycle-level reference model checked every cycle, plus directed literal results.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        mthi = 1'b0, mtlo = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int nvec = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Result of an operation straight from arithmetic: {div_by_zero, hi, lo}.
    function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sp;
        longint unsigned up;
        int              q, r;
        ref_op = '0;
        case (o)
            2'b00: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                ref_op = {1'b0, sp};
            end
            2'b01: begin
                up = longint'(x) * longint'(y);
                ref_op = {1'b0, up};
            end
            2'b10: begin
                if (y == 0) ref_op = {1'b1, x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ref_op = {1'b0, 32'h0, 32'h8000_0000};
                else begin
                    q = $signed(x) / $signed(y);
                    r = $signed(x) % $signed(y);
                    ref_op = {1'b0, r, q};
                end
            end
            default: begin
                if (y == 0) ref_op = {1'b1, x, 32'hFFFF_FFFF};
                else ref_op = {1'b0, x % y, x / y};
            end
        endcase
    endfunction

    // Cycle-level model: 32 busy cycles, then a one-cycle done with the result.
    logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [64:0] m_pend = '0;
    int          m_left = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
            m_hi = '0; m_lo = '0; m_left = 0;
        end else begin
            m_done = 1'b0;
            m_dbz  = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    {m_dbz, m_hi, m_lo} = m_pend;
                end
            end else if (start) begin
                m_pend = ref_op(op, a, b);
                m_busy = 1'b1;
                m_left = 32;
            end else begin
                if (mthi) m_hi = wdata;
                if (mtlo) m_lo = wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("busy", {31'b0, busy}, {31'b0, m_busy});
            cmp("done", {31'b0, done}, {31'b0, m_done});
            cmp("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_dbz});
            cmp("hi", hi, m_hi);
            cmp("lo", lo, m_lo);
        end
    end

    // Called at a negedge; leaves the caller at the negedge of the done cycle.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] rh, output logic [31:0] rl, output logic rz,
                          output int lat, output int bcnt);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = ~x; b = y ^ 32'h5A5A_5A5A;
        lat = 1; bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        cmp("done_seen", {31'b0, done}, 32'd1);
        rh = hi; rl = lo; rz = div_by_zero;
    endtask

    typedef struct {
        logic [1:0]  o;
        logic [31:0] x, y, eh, el;
        logic        ez;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [31:0] rh, rl;
        logic        rz;
        int          lat, bcnt, ndone;

        tbl[0] = '{2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        tbl[1] = '{2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, 1'b0};
        tbl[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        tbl[3] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
        tbl[4] = '{2'b00, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0};
        tbl[5] = '{2'b10, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};

        #1 reset = 1'b0;
        #1;
        cmp("rst_busy", {31'b0, busy}, 32'd0);
        cmp("rst_done", {31'b0, done}, 32'd0);
        cmp("rst_hi", hi, 32'd0);
        cmp("rst_lo", lo, 32'd0);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Unsigned extreme: latency and busy length.
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rh, rl, rz, lat, bcnt);
        cmp("multu_lat", lat, 32'd33);
        cmp("multu_busy", bcnt, 32'd32);
        cmp("multu_hi", rh, 32'hFFFF_FFFE);
        cmp("multu_lo", rl, 32'h0000_0001);

        // Signed multiply, then a divide started in the done cycle.
        @(negedge clk);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, rh, rl, rz, lat, bcnt);
        cmp("mult_hi", rh, 32'hFFFF_FFFF);
        cmp("mult_lo", rl, 32'hFFFF_FFF1);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, rh, rl, rz, lat, bcnt);
        cmp("b2b_lat", lat, 32'd33);
        cmp("div_hi", rh, 32'hFFFF_FFFF);
        cmp("div_lo", rl, 32'hFFFF_FFFD);

        // Divide by zero and signed overflow.
        @(negedge clk);
        run_op(2'b11, 32'd100, 32'd0, rh, rl, rz, lat, bcnt);
        cmp("dz_hi", rh, 32'h0000_0064);
        cmp("dz_lo", rl, 32'hFFFF_FFFF);
        cmp("dz_flag", {31'b0, rz}, 32'd1);
        @(negedge clk);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, rh, rl, rz, lat, bcnt);
        cmp("ovf_hi", rh, 32'h0);
        cmp("ovf_lo", rl, 32'h8000_0000);
        cmp("ovf_flag", {31'b0, rz}, 32'd0);

        foreach (tbl[i]) begin
            @(negedge clk);
            run_op(tbl[i].o, tbl[i].x, tbl[i].y, rh, rl, rz, lat, bcnt);
            cmp($sformatf("tbl%0d_hi", i), rh, tbl[i].eh);
            cmp($sformatf("tbl%0d_lo", i), rl, tbl[i].el);
            cmp($sformatf("tbl%0d_dz", i), {31'b0, rz}, {31'b0, tbl[i].ez});
        end

        // Idle register writes, and writes/starts ignored while busy.
        @(negedge clk);
        mthi = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        mthi = 1'b0;
        cmp("mthi_hi", hi, 32'h1234_5678);
        start = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        mtlo = 1'b1; start = 1'b1; wdata = 32'hDEAD_BEEF; a = 32'd9; b = 32'd9;
        @(negedge clk);
        mtlo = 1'b0; start = 1'b0;
        cmp("busy_hold_hi", hi, 32'h1234_5678);
        ndone = 0; rh = '0; rl = '0;
        for (int k = 0; k < 45; k++) begin
            if (done) begin ndone++; rh = hi; rl = lo; end
            @(negedge clk);
        end
        cmp("ign_ndone", ndone, 32'd1);
        cmp("ign_hi", rh, 32'd0);
        cmp("ign_lo", rl, 32'd42);

        // Reset in the middle of a divide.
        start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        cmp("abort_busy", {31'b0, busy}, 32'd0);
        cmp("abort_hi", hi, 32'd0);
        cmp("abort_lo", lo, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        cmp("abort_ndone", ndone, 32'd0);
        run_op(2'b11, 32'd1000, 32'd3, rh, rl, rz, lat, bcnt);
        cmp("rerun_hi", rh, 32'd1);
        cmp("rerun_lo", rl, 32'd333);

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
